// File: rtl/fpu_status_tracker.sv
// FPU completion tracker: sticky exception flags, saturating per-status event
// counters, an interrupt request and a ready/valid dump engine for counter snapshots.
module fpu_status_tracker #(
    parameter int CNT_W          = 8,
    parameter bit IRQ_ON_INEXACT = 1'b0
) (
    input  logic             clock_100KHz,
    input  logic             reset,
    input  logic             status_valid,
    input  logic [3:0]       status_in,
    input  logic [31:0]      result_in,
    input  logic             clear,
    input  logic             irq_en,
    input  logic             dump_req,
    input  logic             dump_ready,
    output logic             dump_valid,
    output logic [1:0]       dump_idx,
    output logic [CNT_W-1:0] dump_count,
    output logic             dump_busy,
    output logic [3:0]       sticky,
    output logic             bad_code,
    output logic [31:0]      last_result,
    output logic             irq
);

    localparam logic [3:0]       NUM_CODES = 4'd4;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];
    logic [CNT_W-1:0] snap_q [4];
    logic [CNT_W-1:0] snap_d [4];
    logic [3:0]       sticky_q, sticky_d;
    logic             bad_code_q, bad_code_d;
    logic [31:0]      last_result_q, last_result_d;
    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so paths that skip an assignment cannot infer a latch.
        cnt_d         = cnt_q;
        sticky_d      = sticky_q;
        bad_code_d    = bad_code_q;
        last_result_d = last_result_q;

        if (status_valid) begin
            last_result_d = result_in;
        end

        // clear wins over a same-edge completion; the event itself is dropped
        if (clear) begin
            cnt_d      = '{default: '0};
            sticky_d   = '0;
            bad_code_d = 1'b0;
        end else if (status_valid) begin
            if (status_in < NUM_CODES) begin
                if (cnt_q[status_in[1:0]] != CNT_MAX) begin
                    cnt_d[status_in[1:0]] = cnt_q[status_in[1:0]] + CNT_ONE;
                end
                sticky_d[status_in[1:0]] = 1'b1;
            end else begin
                bad_code_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;

        case (state_q)
            ST_IDLE: begin
                // Snapshot uses the pre-edge counters, so a same-edge event is excluded
                if (dump_req) begin
                    snap_d  = cnt_q;
                    idx_d   = 2'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (dump_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values in any statement order.
    // NOTE: the snapshot array is reset as well, so no stale counts survive a reset that aborts a dump.
    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            cnt_q         <= '{default: '0};
            snap_q        <= '{default: '0};
            sticky_q      <= '0;
            bad_code_q    <= 1'b0;
            last_result_q <= '0;
            state_q       <= ST_IDLE;
            idx_q         <= 2'd0;
        end else begin
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            sticky_q      <= sticky_d;
            bad_code_q    <= bad_code_d;
            last_result_q <= last_result_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
        end
    end

    assign dump_busy   = (state_q == ST_SEND);
    assign dump_valid  = dump_busy;
    assign dump_idx    = dump_busy ? idx_q : 2'd0;
    assign dump_count  = dump_busy ? snap_q[idx_q] : '0;
    assign sticky      = sticky_q;
    assign bad_code    = bad_code_q;
    assign last_result = last_result_q;
    assign irq         = irq_en & (sticky_q[1] | sticky_q[2] | bad_code_q |
                                   (IRQ_ON_INEXACT & sticky_q[3]));

endmodule

// File: doc/fpu_status_tracker.md
Name: fpu_status_tracker

Overview:
Consumer-side companion to the FPU. Receives each FPU completion (status code from the FPU_types package plus the 32-bit result) and accumulates sticky exception flags and per-status saturating event counters. It exposes an interrupt and a handshaked dump engine. The dump engine serialises a snapshot of the four counters to a host/debug port. It sits directly downstream of the FPU status_out/data_out outputs.

Parameters:
CNT_W, 8, width of each per-status event counter (saturating)
IRQ_ON_INEXACT, 0, when 1, a sticky INEXACT flag also raises irq

Ports:
clock_100KHz  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
status_valid  input  1  one-cycle pulse: FPU completed an operation
status_in  input  4  FPU status code (g_eStatus: EXACT=0, OVERFLOW=1, UNDERFLOW=2, INEXACT=3)
result_in  input  32  FPU result, sampled with status_valid
clear  input  1  pulse: zero counters, sticky flags, bad_code
irq_en  input  1  interrupt enable (level)
dump_req  input  1  pulse: start counter dump
dump_ready  input  1  sink accepts current dump word
dump_valid  output  1  dump word present
dump_idx  output  2  status code of current dump word
dump_count  output  CNT_W  snapshot count for dump_idx
dump_busy  output  1  dump engine not IDLE
sticky  output  4  bit i set once status code i has been seen since last clear
bad_code  output  1  sticky: status_in > 3 seen with status_valid
last_result  output  32  result_in of most recent valid completion
irq  output  1  interrupt request

Behaviour:
- Reset (async, immediate): all counters, sticky, bad_code, last_result and dump_count = 0. dump_valid, dump_busy and irq = 0. dump_idx = 0. FSM = IDLE.
- Event capture (edge where status_valid=1, clear=0):
  - For code c in 0..3: cnt[c] increments; it saturates at 2^CNT_W-1, with no wrap. sticky[c] is set.
  - For code > 3: no counter changes; bad_code is set.
  - last_result <= result_in for any code.
  - All updates are visible the cycle after the edge (1-cycle latency).
- clear has priority over status_valid. On the same edge, the event is discarded (counters stay 0). last_result is still updated. clear does not affect last_result or the dump FSM.
- irq is combinational from registers: irq_en & (sticky[1] | sticky[2] | bad_code | (IRQ_ON_INEXACT & sticky[3])). It drops the cycle after clear or when irq_en=0.
- Dump FSM states: IDLE, SEND.
  - IDLE: when dump_req=1, copy all four counters into snapshot registers on that edge, set idx=0 and go to SEND. The snapshot reflects values before any same-edge event.
  - SEND: dump_valid=1, dump_idx=idx, dump_count=snap[idx]. A word is accepted on an edge with dump_valid & dump_ready. On acceptance, idx increments; acceptance at idx=3 returns to IDLE. Outputs must stay stable while dump_ready=0 (valid never drops mid-transfer).
  - dump_req while SEND is ignored.
  - Events and clear during SEND update live counters only; the snapshot is untouched.
  - dump_busy = (state == SEND).
  - In IDLE: dump_valid=0, dump_count=0, dump_idx=0.
- Reset mid-dump aborts immediately to IDLE; no partial resume.
- Minimum dump duration: 4 cycles after the dump_req edge with dump_ready held 1.

Test Plan:
- Reset → all outputs 0. Send 3× EXACT, 2× OVERFLOW, 1× INEXACT. dump_req with dump_ready=1 → words (0,3),(1,2),(2,0),(3,1) on 4 consecutive cycles. sticky=4'b1011.
- Saturation, CNT_W=8: 300 back-to-back UNDERFLOW pulses → cnt[2]=255 (no wrap). irq=1 with irq_en=1. irq=0 when irq_en dropped.
- Invalid code: status_valid with status_in=4'd9, result_in=32'h7F800000 → bad_code=1, all counters unchanged, last_result=32'h7F800000, irq=1 (irq_en=1).
- Priority: clear and OVERFLOW status_valid on the same edge → cnt[1]=0, sticky=0, irq=0 next cycle, last_result updated.
- Dump backpressure: dump_ready=0 for 5 cycles at idx=1 → dump_valid, dump_idx=1 and dump_count stable. A new EXACT event during this hold does not change the dumped idx 0 value. A second dump_req is ignored (still 4 words total).
- Reset asserted mid-SEND at idx=2 → dump_valid and dump_busy fall immediately (asynchronously), counters=0. A subsequent dump_req after release → four words all 0.
